// File: rtl/crc_stream_gen.sv
// Streaming CRC generator: passes payload beats through a one-deep output register
// and appends the finished CRC as trailing beats on the same valid/ready stream.
module crc_stream_gen #(
  parameter int              CRC_W  = 16,
  parameter int              DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY   = 16'h8005,
  parameter logic [CRC_W-1:0] INIT   = 16'h0000,
  parameter bit              REFIN  = 1'b0,
  parameter bit              REFOUT = 1'b0,
  parameter logic [CRC_W-1:0] XOROUT = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_is_crc,
  output logic [CRC_W-1:0]  crc_value,
  output logic              crc_done
);

  localparam int         NB       = CRC_W / DATA_W;
  localparam int         NBYTES   = DATA_W / 8;
  localparam logic [2:0] LAST_IDX = 3'(NB - 1);

  if (CRC_W < 8 || CRC_W > 32 || (DATA_W != 8 && DATA_W != 16) || (CRC_W % DATA_W) != 0) begin : g_badParams
    $error("crc_stream_gen: unsupported CRC_W/DATA_W combination");
  end

  typedef enum logic [1:0] {IDLE, DATA, APPEND} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [CRC_W-1:0]    r_crc;
  logic [CRC_W-1:0]    r_crcValue;
  logic                r_crcDone;
  logic                r_mValid;
  logic [DATA_W-1:0]   r_mData;
  logic                r_mLast;
  logic                r_mIsCrc;
  logic [2:0]          r_beatIdx;
  logic                w_outFree;
  logic                w_sReady;
  logic                w_accept;
  logic                w_loadCrc;
  logic                w_lastCrcTaken;
  logic [CRC_W-1:0]    w_crcNext;
  logic [CRC_W-1:0]    w_crcFinal;
  logic [2:0]          w_beatSel;
  logic [CRC_W-1:0]    w_crcShifted;
  logic [DATA_W-1:0]   w_crcBeat;

  function automatic logic [7:0] reflect8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] reflectCrc(input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = c[CRC_W-1-i];
    return r;
  endfunction

  // Bitwise MSB-first update; for 16-bit beats the high byte enters the register first
  function automatic logic [CRC_W-1:0] crcUpdate(input logic [CRC_W-1:0] crcIn,
                                                  input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic [7:0]       b;
    logic             fb;
    c = crcIn;
    for (int k = NBYTES - 1; k >= 0; k--) begin
      b = data[k*8 +: 8];
      if (REFIN) b = reflect8(b);
      for (int i = 7; i >= 0; i--) begin
        fb = c[CRC_W-1] ^ b[i];
        c  = {c[CRC_W-2:0], 1'b0};
        if (fb) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  always_comb begin
    w_crcNext  = crcUpdate(r_crc, s_data);
    w_crcFinal = (REFOUT ? reflectCrc(w_crcNext) : w_crcNext) ^ XOROUT;
  end

  // Reflected CRCs go out least-significant beat first, normal ones most-significant first
  always_comb begin
    w_beatSel    = REFOUT ? r_beatIdx : (LAST_IDX - r_beatIdx);
    w_crcShifted = r_crcValue >> (DATA_W * int'(w_beatSel));
    w_crcBeat    = w_crcShifted[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState    = r_state;
    w_sReady       = 1'b0;
    w_accept       = 1'b0;
    w_loadCrc      = 1'b0;
    w_lastCrcTaken = 1'b0;
    w_outFree      = !r_mValid | m_ready;
    case (r_state)
      IDLE, DATA: begin
        w_sReady = w_outFree & rst;
        w_accept = s_valid & w_sReady;
        if (w_accept && s_last)              w_nextState = APPEND;
        else if (w_accept && r_state == IDLE) w_nextState = DATA;
      end
      APPEND: begin
        w_lastCrcTaken = r_mValid & m_ready & r_mLast;
        w_loadCrc      = w_outFree & !(r_mValid & r_mLast);
        if (w_lastCrcTaken) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output register, running CRC and the CRC-beat counter share one reset domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_crc      <= INIT;
      r_crcValue <= '0;
      r_crcDone  <= 1'b0;
      r_mValid   <= 1'b0;
      r_mData    <= '0;
      r_mLast    <= 1'b0;
      r_mIsCrc   <= 1'b0;
      r_beatIdx  <= '0;
    end else begin
      r_crcDone <= 1'b0;
      if (w_accept) begin
        r_crc <= w_crcNext;
        if (s_last) begin
          r_crcValue <= w_crcFinal;
          r_crcDone  <= 1'b1;
        end
      end
      if (w_lastCrcTaken) begin
        r_crc     <= INIT;
        r_beatIdx <= '0;
      end
      if (w_outFree) begin
        if (w_accept) begin
          r_mValid <= 1'b1;
          r_mData  <= s_data;
          r_mLast  <= 1'b0;
          r_mIsCrc <= 1'b0;
        end else if (w_loadCrc) begin
          r_mValid  <= 1'b1;
          r_mData   <= w_crcBeat;
          r_mLast   <= (r_beatIdx == LAST_IDX);
          r_mIsCrc  <= 1'b1;
          r_beatIdx <= r_beatIdx + 3'd1;
        end else begin
          r_mValid <= 1'b0;
          r_mLast  <= 1'b0;
          r_mIsCrc <= 1'b0;
        end
      end
    end
  end

  assign s_ready   = w_sReady;
  assign m_valid   = r_mValid;
  assign m_data    = r_mData;
  assign m_last    = r_mLast;
  assign m_is_crc  = r_mIsCrc;
  assign crc_value = r_crcValue;
  assign crc_done  = r_crcDone;

endmodule

// File: tb/tb_crc_stream_gen.sv
// Bench for crc_stream_gen: three parameterisations (CRC-16/BUYPASS, CCITT-FALSE, CRC-32)
// driven with "123456789" frames; output beats checked against a scoreboard queue.
module tb_crc_stream_gen;

   typedef struct packed {
      logic [7:0] data;
      logic       isCrc;
      logic       last;
   } beat_t;

   typedef struct {
      int               dutSel;
      bit               randomMode;
      logic [31:0]      expCrc;
      int               nCrc;
      logic [3:0][7:0]  crcBeats;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [2:0]      sValid = '0;
   logic [2:0]      sLast = '0;
   logic [2:0][7:0] sData = '0;
   logic [2:0]      sReady;
   logic [2:0]      mValid;
   logic [2:0]      mReady = 3'b111;
   logic [2:0][7:0] mData;
   logic [2:0]      mLast;
   logic [2:0]      mIsCrc;
   logic [2:0]      crcDone;
   logic [15:0]     crcValA;
   logic [15:0]     crcValB;
   logic [31:0]     crcValC;

   beat_t       expQ[$];
   logic [31:0] doneQ[$];
   int          checks = 0;
   int          errors = 0;
   bit          randomMode = 1'b0;
   vec_t        vecs[4];

   always #5 clk = ~clk;

   crc_stream_gen u_dutA (
      .clk(clk), .rst(rst),
      .s_valid(sValid[0]), .s_ready(sReady[0]), .s_data(sData[0]), .s_last(sLast[0]),
      .m_valid(mValid[0]), .m_ready(mReady[0]), .m_data(mData[0]), .m_last(mLast[0]),
      .m_is_crc(mIsCrc[0]), .crc_value(crcValA), .crc_done(crcDone[0])
   );

   crc_stream_gen #(
      .CRC_W(16), .DATA_W(8), .POLY(16'h1021), .INIT(16'hFFFF),
      .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(16'h0000)
   ) u_dutB (
      .clk(clk), .rst(rst),
      .s_valid(sValid[1]), .s_ready(sReady[1]), .s_data(sData[1]), .s_last(sLast[1]),
      .m_valid(mValid[1]), .m_ready(mReady[1]), .m_data(mData[1]), .m_last(mLast[1]),
      .m_is_crc(mIsCrc[1]), .crc_value(crcValB), .crc_done(crcDone[1])
   );

   crc_stream_gen #(
      .CRC_W(32), .DATA_W(8), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
      .REFIN(1'b1), .REFOUT(1'b1), .XOROUT(32'hFFFFFFFF)
   ) u_dutC (
      .clk(clk), .rst(rst),
      .s_valid(sValid[2]), .s_ready(sReady[2]), .s_data(sData[2]), .s_last(sLast[2]),
      .m_valid(mValid[2]), .m_ready(mReady[2]), .m_data(mData[2]), .m_last(mLast[2]),
      .m_is_crc(mIsCrc[2]), .crc_value(crcValC), .crc_done(crcDone[2])
   );

   // Core comparison: counts every check and reports a mismatch on one line
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [31:0] getCrcVal(input int d);
      if (d == 0) return {16'h0000, crcValA};
      if (d == 1) return {16'h0000, crcValB};
      return crcValC;
   endfunction

   // Downstream readiness: random for the backpressure test, otherwise always ready
   always @(posedge clk) begin
      #1;
      mReady[0]   = randomMode ? 1'($urandom_range(0, 1)) : 1'b1;
      mReady[2:1] = 2'b11;
   end

   // Output monitor: every handshake pops the scoreboard, every crc_done pulse is recorded
   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         for (int d = 0; d < 3; d++) begin
            if (mValid[d] && mReady[d]) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_beat: dut %0d got data 0x%0h crc %0b, expected no beat", d, mData[d], mIsCrc[d]);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("m_data", {24'h0, mData[d]}, {24'h0, e.data});
                  checkOutput("m_is_crc", {31'h0, mIsCrc[d]}, {31'h0, e.isCrc});
                  checkOutput("m_last", {31'h0, mLast[d]}, {31'h0, e.last});
               end
            end
            if (crcDone[d]) doneQ.push_back(getCrcVal(d));
         end
      end
   end

   // Drives one payload beat (entered just after a rising edge) and holds it until accepted
   task automatic applyStimulus(input int d, input logic [7:0] data, input logic last);
      int  waitCycles;
      bit  done;
      waitCycles = 0;
      done = 1'b0;
      if (randomMode && $urandom_range(0, 1) == 1) begin
         repeat ($urandom_range(1, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      sValid[d] = 1'b1;
      sData[d]  = data;
      sLast[d]  = last;
      while (!done) begin
         @(negedge clk);
         if (sReady[d]) begin
            done = 1'b1;
            expQ.push_back('{data: data, isCrc: 1'b0, last: 1'b0});
         end else if (++waitCycles > 200) begin
            done = 1'b1;
            checks++;
            errors++;
            $display("[TB] FAIL s_ready_timeout: dut %0d never accepted 0x%0h", d, data);
         end
         @(posedge clk);
         #1;
      end
      sValid[d] = 1'b0;
      sLast[d]  = 1'b0;
   endtask

   task automatic pushCrc(input logic [3:0][7:0] beats, input int n);
      for (int k = 0; k < n; k++)
         expQ.push_back('{data: beats[k], isCrc: 1'b1, last: (k == n - 1)});
   endtask

   task automatic sendMsg(input int d, input logic [3:0][7:0] beats, input int n);
      for (int i = 0; i < 9; i++)
         applyStimulus(d, 8'h31 + 8'(i), (i == 8));
      pushCrc(beats, n);
   endtask

   task automatic waitDrain();
      int c;
      c = 0;
      while (expQ.size() != 0 && c < 1000) begin
         @(posedge clk);
         c++;
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
      expQ.delete();
   endtask

   task automatic checkCrc(input int d, input logic [31:0] expCrc);
      checkOutput("crc_done_count", 32'(doneQ.size()), 32'd1);
      if (doneQ.size() > 0) checkOutput("crc_done_value", doneQ.pop_front(), expCrc);
      checkOutput("crc_value", getCrcVal(d), expCrc);
      doneQ.delete();
   endtask

   task automatic checkReset();
      for (int d = 0; d < 3; d++) begin
         checkOutput("rst_m_valid", {31'h0, mValid[d]}, 32'd0);
         checkOutput("rst_s_ready", {31'h0, sReady[d]}, 32'd0);
         checkOutput("rst_m_data", {24'h0, mData[d]}, 32'd0);
         checkOutput("rst_m_last", {31'h0, mLast[d]}, 32'd0);
         checkOutput("rst_m_is_crc", {31'h0, mIsCrc[d]}, 32'd0);
         checkOutput("rst_crc_done", {31'h0, crcDone[d]}, 32'd0);
         checkOutput("rst_crc_value", getCrcVal(d), 32'd0);
      end
   endtask

   initial begin
      vecs[0].dutSel = 0; vecs[0].randomMode = 1'b0; vecs[0].expCrc = 32'h0000FEE8;
      vecs[0].nCrc = 2;   vecs[0].crcBeats = {8'h00, 8'h00, 8'hE8, 8'hFE};
      vecs[1].dutSel = 1; vecs[1].randomMode = 1'b0; vecs[1].expCrc = 32'h000029B1;
      vecs[1].nCrc = 2;   vecs[1].crcBeats = {8'h00, 8'h00, 8'hB1, 8'h29};
      vecs[2].dutSel = 2; vecs[2].randomMode = 1'b0; vecs[2].expCrc = 32'hCBF43926;
      vecs[2].nCrc = 4;   vecs[2].crcBeats = {8'hCB, 8'hF4, 8'h39, 8'h26};
      vecs[3].dutSel = 0; vecs[3].randomMode = 1'b1; vecs[3].expCrc = 32'h0000FEE8;
      vecs[3].nCrc = 2;   vecs[3].crcBeats = {8'h00, 8'h00, 8'hE8, 8'hFE};

      repeat (3) @(posedge clk);
      #1;
      checkReset();
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 4; i++) begin
         $display("[TB] vector %0d on dut %0d", i, vecs[i].dutSel);
         randomMode = vecs[i].randomMode;
         sendMsg(vecs[i].dutSel, vecs[i].crcBeats, vecs[i].nCrc);
         waitDrain();
         randomMode = 1'b0;
         checkCrc(vecs[i].dutSel, vecs[i].expCrc);
      end

      $display("[TB] single-beat frame followed immediately by a full frame");
      applyStimulus(0, 8'h00, 1'b1);
      pushCrc({8'h00, 8'h00, 8'h00, 8'h00}, 2);
      sendMsg(0, {8'h00, 8'h00, 8'hE8, 8'hFE}, 2);
      waitDrain();
      checkOutput("b2b_done_count", 32'(doneQ.size()), 32'd2);
      if (doneQ.size() == 2) begin
         checkOutput("b2b_first_crc", doneQ[0], 32'h00000000);
         checkOutput("b2b_second_crc", doneQ[1], 32'h0000FEE8);
      end
      checkOutput("b2b_crc_value", getCrcVal(0), 32'h0000FEE8);
      doneQ.delete();

      $display("[TB] reset mid-frame then full resend");
      for (int i = 0; i < 4; i++)
         applyStimulus(0, 8'h31 + 8'(i), 1'b0);
      waitDrain();
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkReset();
      checkOutput("midrst_no_done", 32'(doneQ.size()), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      sendMsg(0, {8'h00, 8'h00, 8'hE8, 8'hFE}, 2);
      waitDrain();
      checkCrc(0, 32'h0000FEE8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
